// File: rtl/sram_out_arb_ctrl_if.sv
// Bus bundle for sram_out_arb_ctrl: write-burst channel, two reader
// request/response channels and the SRAM-side write/read ports.
// slave  = the controller's view, master = the surrounding environment.
interface sram_out_arb_ctrl_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  // accelerator write burst
  logic          wr_start;
  logic [AW-1:0] wr_base;
  logic [AW:0]   wr_len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_busy;
  logic          wr_done;
  // reader 0 (host read)
  logic          rd0_req_valid;
  logic [AW-1:0] rd0_req_addr;
  logic          rd0_req_ready;
  logic          rd0_rsp_valid;
  logic [DW-1:0] rd0_rsp_data;
  logic          rd0_rsp_ready;
  // reader 1 (drain DMA)
  logic          rd1_req_valid;
  logic [AW-1:0] rd1_req_addr;
  logic          rd1_req_ready;
  logic          rd1_rsp_valid;
  logic [DW-1:0] rd1_rsp_data;
  logic          rd1_rsp_ready;
  // SRAM ports
  logic          sram_wsbn;
  logic [AW-1:0] sram_waddr;
  logic [DW-1:0] sram_wdata;
  logic          sram_csbn;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  wr_start, wr_base, wr_len, wr_valid, wr_data,
    input  rd0_req_valid, rd0_req_addr, rd0_rsp_ready,
    input  rd1_req_valid, rd1_req_addr, rd1_rsp_ready,
    input  sram_rdata,
    output wr_ready, wr_busy, wr_done,
    output rd0_req_ready, rd0_rsp_valid, rd0_rsp_data,
    output rd1_req_ready, rd1_rsp_valid, rd1_rsp_data,
    output sram_wsbn, sram_waddr, sram_wdata, sram_csbn, sram_raddr
  );

  modport master (
    output wr_start, wr_base, wr_len, wr_valid, wr_data,
    output rd0_req_valid, rd0_req_addr, rd0_rsp_ready,
    output rd1_req_valid, rd1_req_addr, rd1_rsp_ready,
    output sram_rdata,
    input  wr_ready, wr_busy, wr_done,
    input  rd0_req_ready, rd0_rsp_valid, rd0_rsp_data,
    input  rd1_req_ready, rd1_rsp_valid, rd1_rsp_data,
    input  sram_wsbn, sram_waddr, sram_wdata, sram_csbn, sram_raddr
  );
endinterface

// File: rtl/sram_out_arb_ctrl.sv
// Output-SRAM controller: sequences accelerator write bursts with an
// auto-incrementing (wrapping) address and arbitrates the single read port
// between rd0 (host) and rd1 (drain DMA) with a 1-cycle registered read.
// Reads are held off for one cycle when they hit the word being written.
// Build option: SRAM_OUT_ARB_RR_EN selects round-robin arbitration;
// without it rd0 has fixed priority over rd1.
module sram_out_arb_ctrl #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst_n,
  sram_out_arb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_DONE} wr_state_t;

  localparam logic [AW:0] LAST_WORD = 1;

  wr_state_t     wr_state, wr_state_next;
  logic [AW-1:0] wr_addr, wr_addr_next;
  logic [AW:0]   wr_remaining, wr_remaining_next;
  logic          wr_accept;

  // write burst state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= WR_IDLE;
      wr_addr      <= '0;
      wr_remaining <= '0;
    end else begin
      wr_state     <= wr_state_next;
      wr_addr      <= wr_addr_next;
      wr_remaining <= wr_remaining_next;
    end
  end

  // write burst sequencing; address wraps naturally at the AW-bit boundary
  always_comb begin
    wr_state_next     = wr_state;
    wr_addr_next      = wr_addr;
    wr_remaining_next = wr_remaining;
    wr_accept         = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (bus.wr_start) begin
          if (bus.wr_len == '0) begin
            wr_state_next = WR_DONE;
          end else begin
            wr_state_next     = WR_BURST;
            wr_addr_next      = bus.wr_base;
            wr_remaining_next = bus.wr_len;
          end
        end
      end
      WR_BURST: begin
        wr_accept = bus.wr_valid;
        if (wr_accept) begin
          wr_addr_next      = wr_addr + 1'b1;
          wr_remaining_next = wr_remaining - 1'b1;
          if (wr_remaining == LAST_WORD) wr_state_next = WR_DONE;
        end
      end
      WR_DONE: wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  assign bus.wr_ready   = (wr_state == WR_BURST);
  assign bus.wr_busy    = (wr_state != WR_IDLE);
  assign bus.wr_done    = (wr_state == WR_DONE);
  assign bus.sram_wsbn  = wr_accept;
  assign bus.sram_waddr = wr_addr;
  assign bus.sram_wdata = bus.wr_data;

  // ---------------- read arbitration ----------------
  logic [1:0]    req_valid, rsp_ready, cand, grant, rsp_valid;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] rd_data;
  logic          rd_pend, rd_owner, slot_free;

  assign req_valid   = {bus.rd1_req_valid, bus.rd0_req_valid};
  assign rsp_ready   = {bus.rd1_rsp_ready, bus.rd0_rsp_ready};
  assign req_addr[0] = bus.rd0_req_addr;
  assign req_addr[1] = bus.rd1_req_addr;

  // the single response slot frees up in the same cycle its owner consumes it
  assign slot_free = !rd_pend || rsp_ready[rd_owner];

  // rst_n gating keeps req_ready low and csbn high while reset is held
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_reader
      assign cand[gi] = rst_n && req_valid[gi] && slot_free &&
                        !(wr_accept && (req_addr[gi] == wr_addr));
      assign rsp_valid[gi] = rd_pend && (rd_owner == 1'(gi));
    end
  endgenerate

`ifdef SRAM_OUT_ARB_RR_EN
  logic rr_ptr, rr_alt;
  assign rr_alt = ~rr_ptr;

  // preferred reader first, otherwise the other one
  always_comb begin
    grant = '0;
    if (cand[rr_ptr])      grant[rr_ptr] = 1'b1;
    else if (cand[rr_alt]) grant[rr_alt] = 1'b1;
  end

  // after a grant, the reader that was not granted becomes preferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (|grant) rr_ptr <= ~grant[1];
  end
`else
  // fixed priority: rd1 only gets the port when rd0 cannot use it
  assign grant = {cand[1] & ~cand[0], cand[0]};
`endif

  // track the outstanding response and its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else if (|grant) begin
      rd_pend  <= 1'b1;
      rd_owner <= grant[1];
    end else if (slot_free) begin
      rd_pend  <= 1'b0;
    end
  end

  // SRAM holds rdata while csbn is high, so a stalled response stays stable
  assign rd_data           = bus.sram_rdata;
  assign bus.sram_csbn     = ~|grant;
  assign bus.sram_raddr    = grant[1] ? req_addr[1] : req_addr[0];
  assign bus.rd0_req_ready = grant[0];
  assign bus.rd1_req_ready = grant[1];
  assign bus.rd0_rsp_valid = rsp_valid[0];
  assign bus.rd1_rsp_valid = rsp_valid[1];
  assign bus.rd0_rsp_data  = rd_data;
  assign bus.rd1_rsp_data  = rd_data;

endmodule

// File: tb/tb_sram_out_arb_ctrl.sv
// Self-checking bench for sram_out_arb_ctrl: SRAM behavioural model,
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_sram_out_arb_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sram_out_arb_ctrl_if #(.AW(13), .DW(32)) bus ();

  sram_out_arb_ctrl #(.AW(13), .DW(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- SRAM behavioural model ----------------
  logic [31:0] sram_mem [8192];
  always @(posedge clk) begin
    if (bus.sram_wsbn)  sram_mem[bus.sram_waddr] <= bus.sram_wdata;
    if (!bus.sram_csbn) bus.sram_rdata <= sram_mem[bus.sram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [8192];
  bit          m_burst, m_done, m_pend;
  int          m_addr, m_rem, m_owner, m_pref;
  logic [31:0] m_data;

  bit          e_wsbn, free;
  bit          cand [2];
  logic        rv [2];
  logic        rr [2];
  logic [12:0] ra [2];
  int          g;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_wr_busy",  bus.wr_busy, 0);
      chk("rst_wr_done",  bus.wr_done, 0);
      chk("rst_wsbn",     bus.sram_wsbn, 0);
      chk("rst_csbn",     bus.sram_csbn, 1);
      chk("rst_rd0_rdy",  bus.rd0_req_ready, 0);
      chk("rst_rd1_rdy",  bus.rd1_req_ready, 0);
      chk("rst_rd0_rsp",  bus.rd0_rsp_valid, 0);
      chk("rst_rd1_rsp",  bus.rd1_rsp_valid, 0);
      m_burst = 0; m_done = 0; m_pend = 0;
      m_addr = 0; m_rem = 0; m_owner = 0; m_pref = 0;
    end else begin
      rv[0] = bus.rd0_req_valid; rv[1] = bus.rd1_req_valid;
      ra[0] = bus.rd0_req_addr;  ra[1] = bus.rd1_req_addr;
      rr[0] = bus.rd0_rsp_ready; rr[1] = bus.rd1_rsp_ready;

      // write side
      e_wsbn = m_burst && bus.wr_valid;
      chk("wr_ready", bus.wr_ready, m_burst);
      chk("wr_busy",  bus.wr_busy, m_burst || m_done);
      chk("wr_done",  bus.wr_done, m_done);
      chk("sram_wsbn", bus.sram_wsbn, e_wsbn);
      if (e_wsbn) begin
        chk("sram_waddr", bus.sram_waddr, m_addr);
        chk("sram_wdata", bus.sram_wdata, bus.wr_data);
      end

      // read side
      free = !m_pend || rr[m_owner];
      for (int i = 0; i < 2; i++)
        cand[i] = rv[i] && free && !(e_wsbn && (int'(ra[i]) == m_addr));
      g = -1;
`ifdef SRAM_OUT_ARB_RR_EN
      if (cand[m_pref])        g = m_pref;
      else if (cand[1-m_pref]) g = 1 - m_pref;
`else
      if (cand[0])      g = 0;
      else if (cand[1]) g = 1;
`endif
      chk("rd0_req_ready", bus.rd0_req_ready, g == 0);
      chk("rd1_req_ready", bus.rd1_req_ready, g == 1);
      chk("sram_csbn", bus.sram_csbn, g < 0);
      if (g >= 0) chk("sram_raddr", bus.sram_raddr, ra[g]);
      chk("rd0_rsp_valid", bus.rd0_rsp_valid, m_pend && m_owner == 0);
      chk("rd1_rsp_valid", bus.rd1_rsp_valid, m_pend && m_owner == 1);
      if (m_pend && m_owner == 0) chk("rd0_rsp_data", bus.rd0_rsp_data, m_data);
      if (m_pend && m_owner == 1) chk("rd1_rsp_data", bus.rd1_rsp_data, m_data);

      // advance the model by one clock
      if (g >= 0) begin
        m_pend = 1; m_owner = g; m_data = ref_mem[ra[g]]; m_pref = 1 - g;
      end else if (m_pend && rr[m_owner]) begin
        m_pend = 0;
      end
      if (e_wsbn) ref_mem[m_addr] = bus.wr_data;
      if (m_done) begin
        m_done = 0;
      end else if (m_burst) begin
        if (bus.wr_valid) begin
          m_addr = (m_addr + 1) % 8192;
          m_rem  = m_rem - 1;
          if (m_rem == 0) begin m_burst = 0; m_done = 1; end
        end
      end else if (bus.wr_start) begin
        if (bus.wr_len == 0) m_done = 1;
        else begin m_burst = 1; m_addr = int'(bus.wr_base); m_rem = int'(bus.wr_len); end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit g0, g1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_start = 0; bus.wr_base = '0; bus.wr_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0;
    bus.rd0_req_valid = 0; bus.rd0_req_addr = '0; bus.rd0_rsp_ready = 1;
    bus.rd1_req_valid = 0; bus.rd1_req_addr = '0; bus.rd1_rsp_ready = 1;
  endtask

  function automatic logic [12:0] rand_addr();
    if (($urandom % 4) == 0) return 13'h1FFC + 13'($urandom % 8);
    return 13'($urandom % 16);
  endfunction

  task automatic rand_step(input bit rst_val);
    cyc();
    rst_n = rst_val;
    if (!bus.rd0_req_valid || g0) begin
      bus.rd0_req_valid = ($urandom % 3) != 0;
      bus.rd0_req_addr  = rand_addr();
    end
    if (!bus.rd1_req_valid || g1) begin
      bus.rd1_req_valid = ($urandom % 3) != 0;
      bus.rd1_req_addr  = rand_addr();
    end
    bus.rd0_rsp_ready = ($urandom % 4) != 0;
    bus.rd1_rsp_ready = ($urandom % 3) != 0;
    bus.wr_start = ($urandom % 6) == 0;
    bus.wr_base  = rand_addr();
    bus.wr_len   = (($urandom % 50) == 0) ? 14'd40 : 14'($urandom % 7);
    bus.wr_valid = ($urandom % 4) != 0;
    bus.wr_data  = $urandom;
    obs();
    g0 = bus.rd0_req_ready;
    g1 = bus.rd1_req_ready;
  endtask

  // ---------------- main sequence ----------------
  logic [12:0] burst_addr [4];
  bit          gr0, gr1, prev1;
  int          n0, n1;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      sram_mem[i] = 32'h5A5A0000 ^ 32'(i);
      ref_mem[i]  = 32'h5A5A0000 ^ 32'(i);
    end
    bus.sram_rdata = '0;
    idle_inputs();
    rst_n = 0;
    bus.rd0_req_valid = 1;  // request held during reset must not be granted
    obs();
    chk("lit_rst_req_ready", bus.rd0_req_ready, 0);
    chk("lit_rst_csbn", bus.sram_csbn, 1);
    obs();
    cyc();
    rst_n = 1;
    idle_inputs();

    // burst across the top of the address space
    burst_addr[0] = 13'h1FFE; burst_addr[1] = 13'h1FFF;
    burst_addr[2] = 13'h0000; burst_addr[3] = 13'h0001;
    cyc();
    bus.wr_start = 1; bus.wr_base = 13'h1FFE; bus.wr_len = 14'd4;
    obs();
    chk("lit_burst_busy_idle", bus.wr_busy, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.wr_start = 0; bus.wr_valid = 1; bus.wr_data = 32'hA0 + 32'(i);
      obs();
      chk("lit_burst_wsbn", bus.sram_wsbn, 1);
      chk("lit_burst_waddr", bus.sram_waddr, burst_addr[i]);
      $display("burst word %0d addr %h data %h", i, bus.sram_waddr, bus.sram_wdata);
    end
    cyc();
    bus.wr_valid = 0;
    obs();
    chk("lit_burst_done", bus.wr_done, 1);
    chk("lit_burst_busy_done", bus.wr_busy, 1);
    cyc();
    obs();
    chk("lit_burst_done_clr", bus.wr_done, 0);
    chk("lit_burst_busy_clr", bus.wr_busy, 0);
    chk("lit_mem_1ffe", sram_mem[13'h1FFE], 32'hA0);
    chk("lit_mem_0000", sram_mem[13'h0000], 32'hA2);
    chk("lit_mem_0001", sram_mem[13'h0001], 32'hA3);
    chk("lit_ref_0001", ref_mem[13'h0001], 32'hA3);

    // zero-length burst
    cyc();
    bus.wr_start = 1; bus.wr_len = 14'd0; bus.wr_valid = 1;
    obs();
    chk("lit_zero_wsbn", bus.sram_wsbn, 0);
    cyc();
    bus.wr_start = 0;
    obs();
    chk("lit_zero_done", bus.wr_done, 1);
    chk("lit_zero_wsbn2", bus.sram_wsbn, 0);
    $display("zero-length burst done=%0b", bus.wr_done);
    cyc();
    bus.wr_valid = 0;
    obs();
    chk("lit_zero_done_clr", bus.wr_done, 0);

    // put 0x55 at address 5
    cyc();
    bus.wr_start = 1; bus.wr_base = 13'd5; bus.wr_len = 14'd1;
    cyc();
    bus.wr_start = 0; bus.wr_valid = 1; bus.wr_data = 32'h55;
    cyc();
    bus.wr_valid = 0;
    cyc();

    // backpressure on rd0
    bus.rd0_req_valid = 1; bus.rd0_req_addr = 13'd5; bus.rd0_rsp_ready = 0;
    obs();
    chk("lit_bp_grant", bus.rd0_req_ready, 1);
    chk("lit_bp_csbn", bus.sram_csbn, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.rd0_req_addr = 13'd6;
      obs();
      chk("lit_bp_rsp_valid", bus.rd0_rsp_valid, 1);
      chk("lit_bp_rsp_data", bus.rd0_rsp_data, 32'h55);
      chk("lit_bp_no_grant", bus.rd0_req_ready, 0);
      $display("backpressure cycle %0d rsp_valid=%0b data=%h", i, bus.rd0_rsp_valid, bus.rd0_rsp_data);
    end
    cyc();
    bus.rd0_rsp_ready = 1;
    obs();
    chk("lit_bp_release_data", bus.rd0_rsp_data, 32'h55);
    chk("lit_bp_regrant", bus.rd0_req_ready, 1);
    cyc();
    bus.rd0_req_valid = 0;
    cyc();

    // write/read hazard at 0x10
    bus.wr_start = 1; bus.wr_base = 13'h10; bus.wr_len = 14'd1;
    cyc();
    bus.wr_start = 0; bus.wr_valid = 1; bus.wr_data = 32'hDEAD;
    bus.rd1_req_valid = 1; bus.rd1_req_addr = 13'h10;
    obs();
    chk("lit_hz_wsbn", bus.sram_wsbn, 1);
    chk("lit_hz_blocked", bus.rd1_req_ready, 0);
    cyc();
    bus.wr_valid = 0;
    obs();
    chk("lit_hz_grant", bus.rd1_req_ready, 1);
    cyc();
    bus.rd1_req_valid = 0;
    obs();
    chk("lit_hz_rsp_valid", bus.rd1_rsp_valid, 1);
    chk("lit_hz_rsp_data", bus.rd1_rsp_data, 32'hDEAD);
    $display("hazard read data=%h", bus.rd1_rsp_data);

    // contention between both readers
    n0 = 0; n1 = 0; prev1 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.rd0_req_valid = 1; bus.rd0_req_addr = 13'h20;
      bus.rd1_req_valid = 1; bus.rd1_req_addr = 13'h21;
      obs();
      gr0 = bus.rd0_req_ready; gr1 = bus.rd1_req_ready;
      n0 += int'(gr0); n1 += int'(gr1);
`ifdef SRAM_OUT_ARB_RR_EN
      chk("lit_cont_one_grant", gr0 ^ gr1, 1);
      if (i > 0) chk("lit_cont_alternate", gr1, !prev1);
`else
      chk("lit_cont_rd0_wins", gr0, 1);
      chk("lit_cont_rd1_loses", gr1, 0);
`endif
      prev1 = gr1;
      $display("contention cycle %0d grant rd0=%0b rd1=%0b", i, gr0, gr1);
    end
`ifdef SRAM_OUT_ARB_RR_EN
    chk("lit_cont_rd0_count", n0, 3);
    chk("lit_cont_rd1_count", n1, 3);
`else
    chk("lit_cont_rd0_count", n0, 6);
`endif
    cyc();
    idle_inputs();
    cyc();

    // reset in the middle of an 8-word burst
    bus.wr_start = 1; bus.wr_base = 13'h40; bus.wr_len = 14'd8;
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus.wr_start = 0; bus.wr_valid = 1; bus.wr_data = 32'hC0 + 32'(i);
    end
    cyc();
    rst_n = 0;
    obs();
    chk("lit_mrst_busy", bus.wr_busy, 0);
    chk("lit_mrst_ready", bus.wr_ready, 0);
    chk("lit_mrst_wsbn", bus.sram_wsbn, 0);
    chk("lit_mrst_csbn", bus.sram_csbn, 1);
    cyc();
    cyc();
    rst_n = 1;
    bus.wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      obs();
      chk("lit_mrst_no_done", bus.wr_done, 0);
      chk("lit_mrst_idle", bus.wr_busy, 0);
      cyc();
    end
    $display("reset mid-burst: busy=%0b done=%0b", bus.wr_busy, bus.wr_done);

    // randomized traffic
    g0 = 0; g1 = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_step(!(i >= 1500 && i < 1503));
      if (bus.rd0_rsp_valid && bus.rd0_rsp_ready)
        $display("rand %0d rd0 rsp %h", i, bus.rd0_rsp_data);
      if (bus.rd1_rsp_valid && bus.rd1_rsp_ready)
        $display("rand %0d rd1 rsp %h", i, bus.rd1_rsp_data);
    end

    cyc();
    idle_inputs();
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
